// File: rtl/shift_right_arithmetic_8bit.sv
// Registered 8-bit arithmetic right shifter (ALU SRA path).
// Three-stage log shifter feeding a result/flag register with one-cycle latency.
module shift_right_arithmetic_8bit (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] A,
    input  logic [2:0] Shamt,
    output logic [7:0] Y,
    output logic       C,
    output logic       Z,
    output logic       N,
    output logic       out_valid
);

    // Handshake: in_valid=1 at a rising edge captures A/Shamt; out_valid=1 for the
    // following cycle marks Y/C/Z/N as that input's result. No backpressure exists,
    // so a new operation can be accepted on every edge.

    logic       sign;
    logic [7:0] s1, s2, s3;
    logic       c1, c2, c3;

    // Each stage fills from the original sign bit. The carry is the last bit shifted
    // out, so a later active stage overrides the carry of an earlier one.
    always_comb begin
        sign = A[7];

        s1 = A;
        c1 = 1'b0;
        if (Shamt[0]) begin
            s1 = {sign, A[7:1]};
            c1 = A[0];
        end

        s2 = s1;
        c2 = c1;
        if (Shamt[1]) begin
            s2 = {{2{sign}}, s1[7:2]};
            c2 = s1[1];
        end

        s3 = s2;
        c3 = c2;
        if (Shamt[2]) begin
            s3 = {{4{sign}}, s2[7:4]};
            c3 = s2[3];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            Y         <= 8'h00;
            C         <= 1'b0;
            Z         <= 1'b0;
            N         <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                Y <= s3;
                C <= c3;
                Z <= (s3 == 8'h00);
                N <= s3[7];
            end
        end
    end

endmodule

// File: tb/tb_shift_right_arithmetic_8bit.sv
// Bench for shift_right_arithmetic_8bit: an integer-arithmetic model checked every
// cycle, literal vectors that pin the model, and randomized traffic with resets.
module tb_shift_right_arithmetic_8bit;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [7:0] A;
    logic [2:0] Shamt;
    logic [7:0] Y;
    logic       C, Z, N, out_valid;

    int n_cmp;
    int n_bad;
    logic chk_en;

    // model state: what the outputs must read after each edge
    logic [7:0] m_y;
    logic       m_c, m_z, m_n, m_v;

    // expected results of accepted operations, oldest first: {n, z, c, y}
    logic [10:0] exp_q[$];

    shift_right_arithmetic_8bit dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .A         (A),
        .Shamt     (Shamt),
        .Y         (Y),
        .C         (C),
        .Z         (Z),
        .N         (N),
        .out_valid (out_valid)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Signed shift done as plain integer division-free arithmetic on an int.
    function automatic logic [10:0] model(input logic [7:0] a, input logic [2:0] sh);
        int         ai;
        int         yi;
        int         k;
        logic [7:0] y;
        logic       c;
        ai = $signed(a);
        k  = int'(sh);
        yi = ai >>> k;
        y  = yi[7:0];
        c  = 1'b0;
        if (k > 0) c = ((ai >> (k - 1)) & 1) != 0;
        return {y[7], (y == 8'h00), c, y};
    endfunction

    // behavioural model of the register stage
    always @(posedge clk) begin
        if (reset) begin
            m_y <= 8'h00; m_c <= 1'b0; m_z <= 1'b0; m_n <= 1'b0; m_v <= 1'b0;
        end else if (in_valid) begin
            {m_n, m_z, m_c, m_y} <= model(A, Shamt);
            m_v <= 1'b1;
        end else begin
            m_v <= 1'b0;
        end
    end

    // per-cycle compare and queue scoreboard
    always @(negedge clk) begin
        if (chk_en) begin
            n_cmp++;
            if (out_valid !== m_v || Y !== m_y || C !== m_c || Z !== m_z || N !== m_n) begin
                n_bad++;
                $display("FAIL cycle_check t=%0t got v=%b Y=%h C=%b Z=%b N=%b want v=%b Y=%h C=%b Z=%b N=%b",
                         $time, out_valid, Y, C, Z, N, m_v, m_y, m_c, m_z, m_n);
            end
            if (out_valid === 1'b1 && exp_q.size() > 0) begin
                logic [10:0] e;
                e = exp_q.pop_front();
                n_cmp++;
                if ({N, Z, C, Y} !== e) begin
                    n_bad++;
                    $display("FAIL queue_check t=%0t got NZC/Y=%b%b%b/%h want %b%b%b/%h",
                             $time, N, Z, C, Y, e[10], e[9], e[8], e[7:0]);
                end
            end
        end
    end

    // driver: apply one cycle of inputs just after a rising edge
    task automatic drive(input logic rst, input logic v, input logic [7:0] a, input logic [2:0] sh);
        @(posedge clk);
        #1;
        reset    = rst;
        in_valid = v;
        A        = a;
        Shamt    = sh;
        if (rst) exp_q.delete();
        else if (v) exp_q.push_back(model(a, sh));
    endtask

    // literal check of the DUT outputs and of the model for the same vector
    task automatic chk_lit(input string name, input logic [7:0] a, input logic [2:0] sh,
                           input logic [7:0] ey, input logic ec, input logic ez, input logic en);
        logic [10:0] mm;
        @(negedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b1 || Y !== ey || C !== ec || Z !== ez || N !== en) begin
            n_bad++;
            $display("FAIL %s got v=%b Y=%h C=%b Z=%b N=%b want v=1 Y=%h C=%b Z=%b N=%b",
                     name, out_valid, Y, C, Z, N, ey, ec, ez, en);
        end
        mm = model(a, sh);
        n_cmp++;
        if (mm !== {en, ez, ec, ey}) begin
            n_bad++;
            $display("FAIL %s_model got %b want %b", name, mm, {en, ez, ec, ey});
        end
    endtask

    initial begin
        logic [7:0] hy;
        logic       hc, hz, hn;
        n_cmp = 0; n_bad = 0; chk_en = 1'b0;
        reset = 1'b1; in_valid = 1'b0; A = 8'h00; Shamt = 3'd0;
        repeat (2) @(posedge clk);
        chk_en = 1'b1;

        @(negedge clk);
        n_cmp++;
        if (Y !== 8'h00 || C !== 1'b0 || Z !== 1'b0 || N !== 1'b0 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state got Y=%h C=%b Z=%b N=%b v=%b want all 0", Y, C, Z, N, out_valid);
        end

        drive(0, 1, 8'b11110000, 3'd1);
        drive(0, 0, 8'h00, 3'd0);
        chk_lit("f0_sh1", 8'b11110000, 3'd1, 8'b11111000, 0, 0, 1);

        drive(0, 1, 8'b11110000, 3'd2);
        drive(0, 1, 8'b00111100, 3'd2);
        chk_lit("f0_sh2", 8'b11110000, 3'd2, 8'b11111100, 0, 0, 1);
        drive(0, 1, 8'b10101010, 3'd3);
        chk_lit("3c_sh2", 8'b00111100, 3'd2, 8'b00001111, 0, 0, 0);
        drive(0, 1, 8'b10101011, 3'd1);
        chk_lit("aa_sh3", 8'b10101010, 3'd3, 8'b11110101, 0, 0, 1);
        drive(0, 1, 8'b01000000, 3'd7);
        chk_lit("ab_sh1", 8'b10101011, 3'd1, 8'b11010101, 1, 0, 1);
        drive(0, 1, 8'b10000001, 3'd7);
        chk_lit("40_sh7", 8'b01000000, 3'd7, 8'h00, 1, 1, 0);
        drive(0, 1, 8'h5A, 3'd0);
        chk_lit("81_sh7", 8'b10000001, 3'd7, 8'hFF, 0, 0, 1);
        drive(0, 0, 8'h33, 3'd5);
        chk_lit("5a_sh0", 8'h5A, 3'd0, 8'h5A, 0, 0, 0);

        // hold: three idle cycles with wiggling inputs
        hy = 8'h5A; hc = 1'b0; hz = 1'b0; hn = 1'b0;
        drive(0, 0, 8'hC3, 3'd6);
        drive(0, 0, 8'h00, 3'd1);
        drive(0, 0, 8'h00, 3'd0);
        @(negedge clk);
        n_cmp++;
        if (Y !== hy || C !== hc || Z !== hz || N !== hn || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL hold got Y=%h C=%b Z=%b N=%b v=%b want Y=%h C=%b Z=%b N=%b v=0",
                     Y, C, Z, N, out_valid, hy, hc, hz, hn);
        end

        // reset overrides a valid input in the same cycle
        drive(1, 1, 8'hF0, 3'd1);
        drive(0, 1, 8'h96, 3'd4);
        @(negedge clk);
        n_cmp++;
        if (Y !== 8'h00 || C !== 1'b0 || Z !== 1'b0 || N !== 1'b0 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_over_valid got Y=%h C=%b Z=%b N=%b v=%b want all 0", Y, C, Z, N, out_valid);
        end
        drive(0, 0, 8'h00, 3'd0);
        chk_lit("after_reset", 8'h96, 3'd4, 8'hF9, 0, 0, 1);

        // randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
                  8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));
        end
        drive(0, 0, 8'h00, 3'd0);
        @(negedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
